// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ======================================================================
// data_mem_responder_if : core <-> data memory request/response bundle
// Revision 1.0
// ======================================================================
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        RespValid;
  logic        Error;
  logic        Stall;

  modport master (
    output MemRead, MemWrite, Addr, WriteData, Funct3,
    input  ReadData, RespValid, Error, Stall
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData, Funct3,
    output ReadData, RespValid, Error, Stall
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ======================================================================
// data_mem_responder : fixed-latency byte/half/word data memory responder
// Revision 1.0
// ======================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  data_mem_responder_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req, req_err, do_write;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, load_val, store_data;
  logic [3:0]    be;
  logic          unused_addr;

  assign unused_addr = ^bus.Addr[31:AW+2];
  assign req         = bus.MemRead | bus.MemWrite;

  // Legality is judged on the live inputs and frozen with the request.
  always_comb begin
    req_err = 1'b0;
    case (bus.Funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.Addr[0];
      3'b010:  req_err = |bus.Addr[1:0];
      3'b100:  req_err = bus.MemWrite;
      3'b101:  req_err = bus.MemWrite | bus.Addr[0];
      default: req_err = 1'b1;
    endcase
    if (bus.MemRead && bus.MemWrite) req_err = 1'b1;
  end

  assign idx     = addr_q[AW+1:2];
  assign word    = mem_q[idx];
  assign shifted = word >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val   = word;
    store_data = wdata_q;
    be         = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        load_val   = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
        store_data = {4{wdata_q[7:0]}};
        be         = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        load_val   = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
        store_data = {2{wdata_q[15:0]}};
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_val   = word;
        store_data = wdata_q;
        be         = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    bus.Stall = 1'b0;
    case (state_q)
      IDLE: begin
        rdata_d = '0;
        if (req) begin
          bus.Stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = CNT_LOAD;
          addr_d    = bus.Addr[AW+1:0];
          wdata_d   = bus.WriteData;
          f3_d      = bus.Funct3;
          wr_d      = bus.MemWrite;
          err_d     = req_err;
        end
      end
      BUSY: begin
        bus.Stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (!wr_q && !err_q) ? load_val : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory has no reset; an abort simply never reaches the write edge.
  assign do_write = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q && !err_q && !reset;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= store_data[8*l +: 8];
      end
    end
  end

  assign bus.RespValid = (state_q == RESP) && !reset;
  assign bus.Error     = bus.RespValid && err_q;
  assign bus.ReadData  = bus.RespValid ? rdata_q : 32'd0;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ======================================================================
// tb_data_mem_responder : directed self-checking bench, LATENCY=2, 256 words
// Revision 1.0
// ======================================================================
module tb_data_mem_responder;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (2)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Presents one request and holds it until the response strobe is seen.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rdata,
                        input logic exp_err);
    logic        ok, leak, err;
    logic [31:0] rdata;
    int          lat, stalls;
    ok = 1'b0; leak = 1'b0; err = 1'b0; rdata = '0; lat = 0; stalls = 0;
    @(negedge clk);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Addr      = addr;
    bus.WriteData = wdata;
    bus.Funct3    = f3;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.Stall) stalls++;
      if (bus.RespValid) begin
        ok    = 1'b1;
        lat   = c;
        rdata = bus.ReadData;
        err   = bus.Error;
        break;
      end
      if (bus.Error || (bus.ReadData != 32'd0)) leak = 1'b1;
      @(negedge clk);
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    check_eq({tag, "_resp_seen"}, {31'd0, ok}, 32'd1);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_error"}, {31'd0, err}, {31'd0, exp_err});
    check_eq({tag, "_latency"}, lat, 32'd3);
    check_eq({tag, "_stall_cycles"}, stalls, 32'd3);
    check_eq({tag, "_quiet_outputs"}, {31'd0, leak}, 32'd0);
  endtask

  initial begin
    logic seen;
    n_pass        = 0;
    n_total       = 0;
    reset         = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    bus.Funct3    = 3'b010;

    repeat (3) @(negedge clk);
    check_eq("rst_respvalid", {31'd0, bus.RespValid}, 32'd0);
    check_eq("rst_error", {31'd0, bus.Error}, 32'd0);
    check_eq("rst_readdata", bus.ReadData, 32'd0);
    check_eq("rst_stall_idle", {31'd0, bus.Stall}, 32'd0);
    bus.MemRead = 1'b1;
    #1;
    check_eq("rst_stall_req", {31'd0, bus.Stall}, 32'd1);
    bus.MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_op("sw_10",   1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
    run_op("lw_10",   1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
    run_op("lb_13",   1'b1, 1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
    run_op("lbu_13",  1'b1, 1'b0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 1'b0);
    run_op("lh_10",   1'b1, 1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0);
    run_op("lhu_12",  1'b1, 1'b0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 1'b0);
    run_op("sb_11",   1'b0, 1'b1, 32'h11, 32'h55,       3'b000, 32'h0,        1'b0);
    run_op("lw_10b",  1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0);

    run_op("lw_12_mis", 1'b1, 1'b0, 32'h12, 32'h0,        3'b010, 32'h0, 1'b1);
    run_op("sh_11_mis", 1'b0, 1'b1, 32'h11, 32'hFFFF,     3'b001, 32'h0, 1'b1);
    run_op("rd_wr_both", 1'b1, 1'b1, 32'h10, 32'h0,       3'b010, 32'h0, 1'b1);
    run_op("sbu_store", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1);
    run_op("f3_011",    1'b1, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0, 1'b1);
    run_op("lw_10c",    1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0);

    run_op("sw_400", 1'b0, 1'b1, 32'h400, 32'h12345678, 3'b010, 32'h0,        1'b0);
    run_op("lw_0",   1'b1, 1'b0, 32'h0,   32'h0,        3'b010, 32'h12345678, 1'b0);

    run_op("sw_20", 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    bus.MemWrite  = 1'b1;
    bus.Addr      = 32'h20;
    bus.WriteData = 32'h11111111;
    bus.Funct3    = 3'b010;
    @(negedge clk);
    check_eq("abort_busy_stall", {31'd0, bus.Stall}, 32'd1);
    reset        = 1'b1;
    bus.MemWrite = 1'b0;
    @(negedge clk);
    check_eq("abort_rst_respvalid", {31'd0, bus.RespValid}, 32'd0);
    check_eq("abort_rst_stall", {31'd0, bus.Stall}, 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.RespValid) seen = 1'b1;
    end
    check_eq("abort_no_resp", {31'd0, seen}, 32'd0);
    run_op("lw_20",  1'b1, 1'b0, 32'h20, 32'h0,    3'b010, 32'hA5A5A5A5, 1'b0);
    run_op("sh_22",  1'b0, 1'b1, 32'h22, 32'hCAFE, 3'b001, 32'h0,        1'b0);
    run_op("lw_20b", 1'b1, 1'b0, 32'h20, 32'h0,    3'b010, 32'hCAFEA5A5, 1'b0);
    run_op("lh_22",  1'b1, 1'b0, 32'h22, 32'h0,    3'b001, 32'hFFFFCAFE, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
